alu_md_unit: RTL and testbench
==============================

Name: alu_md_unit

Overview:
- Parametrised successor to the single-cycle ALU decoder.
- Decodes ALUOp/funct3/funct7 for the full RV32I ALU set plus RV M-extension MUL/DIV/DIVU/REM/REMU.
- Executes the operation and returns a registered result over a valid/ready handshake.
- Sits in the execute stage; base ops take 1 cycle, multiply and divide are iterative multi-cycle.

Parameters:
- XLEN, 32, operand/result width; power of two, at least 8.
- MULDIV_EN, 1, 1 = M-extension ops decoded and executed; 0 = M encodings flagged illegal.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- kill  input  1  synchronous abort of the in-flight op.
- ALUOp  input  2  00 add, 01 sub, 10 decode funct fields, 11 reserved.
- opb5  input  1  opcode bit 5 (1 = R-type).
- funct3  input  3  instruction funct3.
- funct7b5  input  1  funct7 bit 5.
- funct7b0  input  1  funct7 bit 0 (M-extension select).
- src_a  input  XLEN  operand A.
- src_b  input  XLEN  operand B.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- result  output  XLEN  operation result.
- zero  output  1  result equals 0.
- illegal  output  1  undecodable op; qualified by out_valid.

Behaviour:
- Reset: reset_n low at a clock edge forces IDLE and clears out_valid, result, zero, illegal and all iteration state. This applies mid-operation too; any partial result is discarded.
- Accept: transfer occurs on an edge with in_valid & in_ready; operands and decoded op are latched.
- Decode, ALUOp=10, non-M:
  - funct3 000: sub if funct7b5&opb5, else add.
  - 001 sll, 010 slt, 011 sltu, 100 xor.
  - 101: sra if funct7b5, else srl (R- and I-type alike).
  - 110 or, 111 and.
  - Shift amount = src_b[log2(XLEN)-1:0].
- Decode, M-extension: selected when ALUOp=10 & opb5 & funct7b0 & MULDIV_EN.
  - funct3 000 MUL (low XLEN bits).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
  - 001/010/011 (MULH*) are illegal.
- ALUOp=11, or M encodings with MULDIV_EN=0: illegal=1, result=0, latency 1.
- States:
  - IDLE: on accept, go to ALU (base op, illegal, or div special case), MUL or DIV.
  - ALU: compute, load output regs, go to DONE. Latency: accept edge N -> out_valid at N+1.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, XLEN iterations. out_valid at N+XLEN+1.
  - DIV: restoring divide on operand magnitudes (signed ops), XLEN iterations, then sign fixup in the final iteration cycle. out_valid at N+XLEN+1.
  - DONE: out_valid=1; result/zero/illegal stable. On out_ready go to IDLE, in_ready high the next cycle. No back-to-back accept in the same cycle as output handoff.
- Divide special cases, resolved in the ALU path with latency 1:
  - divisor 0: quotient = all ones, remainder = src_a.
  - signed overflow (src_a = MIN, src_b = -1): quotient = MIN, remainder = 0.
- Sign rules:
  - quotient sign = sign(a) xor sign(b).
  - remainder sign = sign(a).
  - slt signed compare; sltu unsigned.
  - MUL result is identical for signed and unsigned operands.
- kill: in MUL/DIV/ALU/DONE, next state IDLE with out_valid=0. kill in IDLE has no effect. reset_n has priority over kill.
- in_valid while busy is ignored (in_ready=0); the requester holds it.

Test Plan:
1. Reset with out_valid high in DONE -> after one edge with reset_n=0: out_valid=0, result=0, in_ready=1.
2. ALUOp=10, opb5=1, funct3=000, funct7b5=1, a=5, b=7 -> result=0xFFFFFFFE, out_valid one cycle after accept. funct3=101, funct7b5=1, a=0x80000000, b=4 -> 0xF8000000. funct3=011, a=1, b=0xFFFFFFFF -> 1.
3. MUL a=0xFFFFFFFD (-3), b=7 -> 0xFFFFFFEB, out_valid exactly 33 cycles after accept (XLEN=32). Hold out_ready=0 for 5 cycles -> result stable, in_ready=0.
4. DIV a=-7, b=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=7, b=0 -> 0xFFFFFFFF in 1 cycle; REM a=0x80000000, b=-1 -> 0, zero=1.
5. kill asserted 10 cycles into a DIV -> next cycle IDLE, out_valid never asserts; a new ADD of 2+3 then returns 5.
6. MULDIV_EN=0 build, MUL encoding -> illegal=1, result=0. ALUOp=11 -> illegal=1 in either build. XLEN=8 build, DIVU 200/7 -> 28, REMU -> 4, latency 9 cycles.

Source files
------------

// File: rtl/alu_md_unit.sv
// alu_md_unit: execute-stage ALU with iterative RV32M multiply/divide.
//   Decodes ALUOp/funct3/funct7 into an operation, latches operands on a
//   valid/ready accept and returns a registered result held until accepted.
//   Base ops take one cycle; MUL is radix-2 shift-add and DIV/REM are
//   restoring divides, both XLEN iterations plus one finishing cycle.
// Ports:
//   clk, reset_n (sync, active low)
//   in_valid/in_ready       request handshake (in_ready only in IDLE)
//   kill                    abort of the in-flight op
//   ALUOp, opb5, funct3, funct7b5, funct7b0   decode fields
//   src_a, src_b            operands
//   out_valid/out_ready     result handshake
//   result, zero, illegal   registered outputs, qualified by out_valid
module alu_md_unit #(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            kill,
  input  logic [1:0]      ALUOp,
  input  logic            opb5,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_ALU, S_MUL, S_DIV, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_t;

  state_t          state, nxt;
  op_t             dec_op, op_q;
  logic            dec_div, dec_sgn, div_special;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] acc, opa, opb;   // acc: product / partial remainder
  logic            sa, sb;          // operand signs for divide fixup
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] alu_res, q_fix, r_fix, div_res, rem_nx, quo_nx;
  logic [XLEN:0]   rem_sh, diff;
  logic            last;

  // ---- decode ----
  always_comb begin
    dec_op = OP_ILL;
    case (ALUOp)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (opb5 && funct7b0) begin
          if (MULDIV_EN) begin
            case (funct3)
              3'b000:  dec_op = OP_MUL;
              3'b100:  dec_op = OP_DIV;
              3'b101:  dec_op = OP_DIVU;
              3'b110:  dec_op = OP_REM;
              3'b111:  dec_op = OP_REMU;
              default: dec_op = OP_ILL;   // MULH/MULHSU/MULHU decode as illegal
            endcase
          end
        end else begin
          case (funct3)
            3'b000:  dec_op = (funct7b5 && opb5) ? OP_SUB : OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = funct7b5 ? OP_SRA : OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end
      end
      default: dec_op = OP_ILL;
    endcase
  end

  assign dec_div     = dec_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign dec_sgn     = dec_op inside {OP_DIV, OP_REM};
  // Divide by zero and signed overflow have fixed answers; finish them in one cycle.
  assign div_special = dec_div && ((src_b == '0) || (dec_sgn && src_a == MIN && (&src_b)));
  assign a_mag       = (dec_sgn && src_a[XLEN-1]) ? (~src_a + 1'b1) : src_a;
  assign b_mag       = (dec_sgn && src_b[XLEN-1]) ? (~src_b + 1'b1) : src_b;

  // ---- single-cycle path (also the divide special cases, operands raw) ----
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = opa + opb;
      OP_SUB:  alu_res = opa - opb;
      OP_SLL:  alu_res = opa << opb[SW-1:0];
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, opa < opb};
      OP_XOR:  alu_res = opa ^ opb;
      OP_SRL:  alu_res = opa >> opb[SW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(opa) >>> opb[SW-1:0]);
      OP_OR:   alu_res = opa | opb;
      OP_AND:  alu_res = opa & opb;
      OP_DIV, OP_DIVU: alu_res = (opb == '0) ? '1 : MIN;
      OP_REM, OP_REMU: alu_res = (opb == '0) ? opa : '0;
      default: alu_res = '0;
    endcase
  end

  // ---- restoring divide step: opa holds dividend bits shifting into quotient ----
  assign rem_sh = {acc, opa[XLEN-1]};
  assign diff   = rem_sh - {1'b0, opb};
  assign rem_nx = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nx = {opa[XLEN-2:0], ~diff[XLEN]};
  assign q_fix  = (op_q == OP_DIV && (sa ^ sb)) ? (~opa + 1'b1) : opa;
  assign r_fix  = (op_q == OP_REM && sa) ? (~acc + 1'b1) : acc;
  assign div_res = (op_q inside {OP_DIV, OP_DIVU}) ? q_fix : r_fix;
  assign last   = (cnt == CW'(XLEN));

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (in_valid) begin
        if (dec_op == OP_MUL)            nxt = S_MUL;
        else if (dec_div && !div_special) nxt = S_DIV;
        else                              nxt = S_ALU;
      end
      S_ALU:  nxt = S_DONE;
      S_MUL:  if (last) nxt = S_DONE;
      S_DIV:  if (last) nxt = S_DONE;
      S_DONE: if (out_ready) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (kill && state != S_IDLE) nxt = S_IDLE;
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // ---- datapath ----
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_q <= OP_ADD; acc <= '0; opa <= '0; opb <= '0;
      sa <= 1'b0; sb <= 1'b0; cnt <= '0;
      result <= '0; zero <= 1'b0; illegal <= 1'b0;
    end else if (!kill || state == S_IDLE) begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q <= dec_op;
          sa   <= src_a[XLEN-1];
          sb   <= src_b[XLEN-1];
          acc  <= '0;
          cnt  <= '0;
          opa  <= (dec_div && !div_special) ? a_mag : src_a;
          opb  <= (dec_div && !div_special) ? b_mag : src_b;
        end
        S_ALU: begin
          result  <= alu_res;
          zero    <= (alu_res == '0);
          illegal <= (op_q == OP_ILL);
        end
        S_MUL: begin
          if (last) begin
            result <= acc; zero <= (acc == '0); illegal <= 1'b0;
          end else begin
            if (opb[0]) acc <= acc + opa;
            opa <= opa << 1;
            opb <= opb >> 1;
            cnt <= cnt + CW'(1);
          end
        end
        S_DIV: begin
          if (last) begin
            result <= div_res; zero <= (div_res == '0); illegal <= 1'b0;
          end else begin
            acc <= rem_nx;
            opa <= quo_nx;
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// Bench for alu_md_unit: three builds (32-bit with M, 32-bit without M,
// 8-bit with M), directed steps then randomized ops checked against an
// arithmetic reference model of the instruction semantics.
module tb_alu_md_unit;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  iv = '0;
  logic [2:0]  ir, ov, zr, il;
  logic        kill = 1'b0;
  logic [1:0]  aluop = '0;
  logic        opb5 = 1'b0, f7b5 = 1'b0, f7b0 = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        out_ready = 1'b1;
  logic [31:0] rs0, rs1;
  logic [7:0]  rs2;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  alu_md_unit #(.XLEN(32), .MULDIV_EN(1'b1)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]), .kill(kill),
    .ALUOp(aluop), .opb5(opb5), .funct3(f3), .funct7b5(f7b5), .funct7b0(f7b0),
    .src_a(src_a), .src_b(src_b), .out_valid(ov[0]), .out_ready(out_ready),
    .result(rs0), .zero(zr[0]), .illegal(il[0]));
  alu_md_unit #(.XLEN(32), .MULDIV_EN(1'b0)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]), .kill(kill),
    .ALUOp(aluop), .opb5(opb5), .funct3(f3), .funct7b5(f7b5), .funct7b0(f7b0),
    .src_a(src_a), .src_b(src_b), .out_valid(ov[1]), .out_ready(out_ready),
    .result(rs1), .zero(zr[1]), .illegal(il[1]));
  alu_md_unit #(.XLEN(8), .MULDIV_EN(1'b1)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]), .kill(kill),
    .ALUOp(aluop), .opb5(opb5), .funct3(f3), .funct7b5(f7b5), .funct7b0(f7b0),
    .src_a(src_a[7:0]), .src_b(src_b[7:0]), .out_valid(ov[2]), .out_ready(out_ready),
    .result(rs2), .zero(zr[2]), .illegal(il[2]));

  function automatic logic [31:0] get_rs(int w);
    case (w)
      0: return rs0;
      1: return rs1;
      default: return {24'd0, rs2};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Instruction semantics with plain integer arithmetic; returns {illegal, result}.
  function automatic logic [32:0] model(int xl, bit men, logic [1:0] aop, bit o5,
                                        logic [2:0] fn3, bit fb5, bit fb0,
                                        logic [31:0] a, logic [31:0] b);
    longint mask = (longint'(1) << xl) - 1;
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    longint sa = ua[xl-1] ? ua - (longint'(1) << xl) : ua;
    longint sb = ub[xl-1] ? ub - (longint'(1) << xl) : ub;
    longint r = 0;
    int sh = int'(ub % xl);
    bit ill = 1'b0;
    case (aop)
      2'd0: r = ua + ub;
      2'd1: r = ua - ub;
      2'd3: ill = 1'b1;
      default: begin
        if (o5 && fb0) begin
          if (!men) ill = 1'b1;
          else case (fn3)
            3'd0: r = ua * ub;
            3'd4: r = (ub == 0) ? -1 : sa / sb;
            3'd5: r = (ub == 0) ? -1 : ua / ub;
            3'd6: r = (ub == 0) ? sa : sa % sb;
            3'd7: r = (ub == 0) ? ua : ua % ub;
            default: ill = 1'b1;
          endcase
        end else case (fn3)
          3'd0: r = (fb5 && o5) ? ua - ub : ua + ub;
          3'd1: r = ua << sh;
          3'd2: r = (sa < sb) ? 1 : 0;
          3'd3: r = (ua < ub) ? 1 : 0;
          3'd4: r = ua ^ ub;
          3'd5: r = fb5 ? (sa >>> sh) : (ua >> sh);
          3'd6: r = ua | ub;
          default: r = ua & ub;
        endcase
      end
    endcase
    if (ill) r = 0;
    return {ill, 32'(r & mask)};
  endfunction

  function automatic int model_lat(int xl, bit men, logic [1:0] aop, bit o5,
                                   logic [2:0] fn3, bit fb0, logic [31:0] a, logic [31:0] b);
    longint mask = (longint'(1) << xl) - 1;
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    if (!(aop == 2'd2 && o5 && fb0 && men)) return 1;
    if (fn3 == 3'd0) return xl + 1;
    if (fn3 inside {3'd1, 3'd2, 3'd3}) return 1;
    if (ub == 0) return 1;
    if ((fn3 == 3'd4 || fn3 == 3'd6) && ua == (longint'(1) << (xl - 1)) && ub == mask) return 1;
    return xl + 1;
  endfunction

  task automatic setup(input logic [1:0] aop, input bit o5, input logic [2:0] fn3,
                       input bit fb5, input bit fb0, input logic [31:0] a, input logic [31:0] b);
    aluop = aop; opb5 = o5; f3 = fn3; f7b5 = fb5; f7b0 = fb0; src_a = a; src_b = b;
  endtask

  // Full transaction on build w; called at #1 after a clock edge with the DUT idle.
  task automatic do_op(input int w, input logic [1:0] aop, input bit o5, input logic [2:0] fn3,
                       input bit fb5, input bit fb0, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input string tag);
    int xl = (w == 2) ? 8 : 32;
    bit men = (w != 1);
    logic [32:0] m = model(xl, men, aop, o5, fn3, fb5, fb0, a, b);
    int el = model_lat(xl, men, aop, o5, fn3, fb0, a, b);
    int n = 0;
    setup(aop, o5, fn3, fb5, fb0, a, b);
    out_ready = (hold == 0);
    chk({tag, ".in_ready"}, 32'(ir[w]), 32'd1);
    iv[w] = 1'b1;
    @(posedge clk); #1;
    iv = '0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ov[w] && n < 200);
    chk({tag, ".latency"}, n, el);
    chk({tag, ".result"}, get_rs(w), m[31:0]);
    chk({tag, ".zero"}, 32'(zr[w]), 32'(m[31:0] == 32'd0));
    chk({tag, ".illegal"}, 32'(il[w]), 32'(m[32]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_result"}, get_rs(w), m[31:0]);
      chk({tag, ".hold_valid"}, {31'd0, ov[w]}, 32'd1);
      chk({tag, ".hold_in_ready"}, {31'd0, ir[w]}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ".after_valid"}, {31'd0, ov[w]}, 32'd0);
    chk({tag, ".after_in_ready"}, {31'd0, ir[w]}, 32'd1);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic rnd_op(input int w, input string tag);
    logic [1:0] aop = ($urandom_range(0, 7) < 6) ? 2'd2 : 2'($urandom_range(0, 3));
    logic [31:0] a = rnd_val();
    logic [31:0] b = rnd_val();
    if (w == 2 && $urandom_range(0, 1) == 1) begin
      a = {24'd0, 8'h80}; b = {24'd0, 8'hFF};
    end
    do_op(w, aop, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), a, b, 0, tag);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("reset.in_ready", {29'd0, ir}, 32'h7);
    chk("reset.out_valid", {29'd0, ov}, 32'h0);
    chk("reset.result", rs0, 32'd0);

    // reset while holding a result in DONE
    setup(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd9, 32'd4);
    out_ready = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1 iv = '0;
    @(posedge clk); #1;
    chk("rst_done.pre_valid", {31'd0, ov[0]}, 32'd1);
    chk("rst_done.pre_result", rs0, 32'd13);
    reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    chk("rst_done.out_valid", {31'd0, ov[0]}, 32'd0);
    chk("rst_done.result", rs0, 32'd0);
    chk("rst_done.in_ready", {31'd0, ir[0]}, 32'd1);
    out_ready = 1'b1;

    // base ops
    do_op(0, 2'd2, 1'b1, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, 0, "sub");
    do_op(0, 2'd2, 1'b0, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 0, "srai");
    do_op(0, 2'd2, 1'b1, 3'd3, 1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF, 0, "sltu");
    do_op(0, 2'd2, 1'b1, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 0, "slt");
    do_op(0, 2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd3, 32'd3, 0, "aluop_sub");

    // multiply with output backpressure
    do_op(0, 2'd2, 1'b1, 3'd0, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7, 5, "mul");

    // divides and special cases
    do_op(0, 2'd2, 1'b1, 3'd4, 1'b0, 1'b1, -32'sd7, 32'd2, 0, "div");
    do_op(0, 2'd2, 1'b1, 3'd6, 1'b0, 1'b1, -32'sd7, 32'd2, 0, "rem");
    do_op(0, 2'd2, 1'b1, 3'd5, 1'b0, 1'b1, 32'd7, 32'd0, 0, "divu_by0");
    do_op(0, 2'd2, 1'b1, 3'd6, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
    do_op(0, 2'd2, 1'b1, 3'd4, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    do_op(0, 2'd2, 1'b1, 3'd1, 1'b0, 1'b1, 32'd3, 32'd3, 0, "mulh_ill");
    do_op(0, 2'd3, 1'b0, 3'd0, 1'b0, 1'b0, 32'd3, 32'd3, 0, "aluop11");

    // kill mid-divide
    setup(2'd2, 1'b1, 3'd4, 1'b0, 1'b1, 32'd100, 32'd3);
    iv[0] = 1'b1;
    @(posedge clk); #1 iv = '0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    chk("kill.in_ready", {31'd0, ir[0]}, 32'd1);
    chk("kill.out_valid", {31'd0, ov[0]}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov[0]) seen = 1'b1;
    end
    chk("kill.never_valid", {31'd0, seen}, 32'd0);
    do_op(0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd2, 32'd3, 0, "add_after_kill");

    // no-M build and 8-bit build
    do_op(1, 2'd2, 1'b1, 3'd0, 1'b0, 1'b1, 32'd6, 32'd7, 0, "nom_mul");
    do_op(1, 2'd3, 1'b1, 3'd0, 1'b0, 1'b0, 32'd6, 32'd7, 0, "nom_aluop11");
    do_op(1, 2'd2, 1'b1, 3'd7, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 0, "nom_and");
    do_op(2, 2'd2, 1'b1, 3'd5, 1'b0, 1'b1, 32'd200, 32'd7, 0, "x8_divu");
    do_op(2, 2'd2, 1'b1, 3'd7, 1'b0, 1'b1, 32'd200, 32'd7, 0, "x8_remu");
    do_op(2, 2'd2, 1'b1, 3'd0, 1'b0, 1'b1, 32'd13, 32'd21, 0, "x8_mul");

    // randomized traffic against the model
    for (int i = 0; i < 60; i++) rnd_op(0, "rnd32");
    for (int i = 0; i < 15; i++) rnd_op(1, "rnd_nom");
    for (int i = 0; i < 40; i++) rnd_op(2, "rnd8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
